// File: rtl/reg_write_arbiter16.sv
// Round-robin owner selection for the shared register-file write port.
// One idle cycle always separates grants; an optional hold limit forces release.
module reg_write_arbiter16 #(
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic        gnt_valid,
    output logic [3:0]  gnt_idx,
    output logic [15:0] gnt_onehot,
    output logic        timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

    state_t             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [3:0]         gnt_idx_q, gnt_idx_d;
    logic [15:0]        gnt_onehot_q, gnt_onehot_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [3:0]         win_idx;
    logic [3:0]         cand;

    // Scan starts at the pointer and wraps, so the last owner becomes lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d      = GRANT;
                    gnt_valid_d  = 1'b1;
                    gnt_idx_d    = win_idx;
                    gnt_onehot_d = 16'd1 << win_idx;
                    hold_cnt_d   = HOLD_W'(1);
                end
            end
            GRANT: begin
                // A dropped request wins over the hold limit, so no timeout is raised then.
                if (!req[gnt_idx_q] ||
                    ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT))) begin
                    state_d      = IDLE;
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = 4'd0;
                    gnt_onehot_d = 16'd0;
                    ptr_d        = gnt_idx_q + 4'd1;
                    hold_cnt_d   = '0;
                    timeout_d    = req[gnt_idx_q];
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d      = IDLE;
                gnt_valid_d  = 1'b0;
                gnt_idx_d    = 4'd0;
                gnt_onehot_d = 16'd0;
                hold_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 4'd0;
            hold_cnt_q   <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= 4'd0;
            gnt_onehot_q <= 16'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_reg_write_arbiter16.sv
// Directed bench for reg_write_arbiter16: three instances cover the default,
// short (4-cycle) and disabled hold limits.
module tb_reg_write_arbiter16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_a, req_t, req_z;

    logic        gnt_valid_a, gnt_valid_t, gnt_valid_z;
    logic [3:0]  gnt_idx_a, gnt_idx_t, gnt_idx_z;
    logic [15:0] gnt_onehot_a, gnt_onehot_t, gnt_onehot_z;
    logic        timeout_a, timeout_t, timeout_z;

    int n_cmp;
    int n_bad;

    reg_write_arbiter16 #(.MAX_HOLD(64), .HOLD_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .gnt_valid(gnt_valid_a), .gnt_idx(gnt_idx_a),
        .gnt_onehot(gnt_onehot_a), .timeout(timeout_a)
    );

    reg_write_arbiter16 #(.MAX_HOLD(4), .HOLD_W(8)) dut_t (
        .clk(clk), .rst_n(rst_n), .req(req_t),
        .gnt_valid(gnt_valid_t), .gnt_idx(gnt_idx_t),
        .gnt_onehot(gnt_onehot_t), .timeout(timeout_t)
    );

    reg_write_arbiter16 #(.MAX_HOLD(0), .HOLD_W(8)) dut_z (
        .clk(clk), .rst_n(rst_n), .req(req_z),
        .gnt_valid(gnt_valid_z), .gnt_idx(gnt_idx_z),
        .gnt_onehot(gnt_onehot_z), .timeout(timeout_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 16'd0;
        req_t = 16'd0;
        req_z = 16'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 16'hFFFF;
        req_t = 16'hFFFF;
        req_z = 16'hFFFF;
        #3;
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a, timeout_a} !== 22'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_a got v=%0b i=%0d oh=%h to=%0b want all 0",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a, timeout_a);
        end
        tick();
        tick();
        n_cmp++;
        if ({gnt_valid_t, gnt_idx_t, gnt_onehot_t, timeout_t,
             gnt_valid_z, gnt_idx_z, gnt_onehot_z, timeout_z} !== 44'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_tz got t:%0b/%0d/%h/%0b z:%0b/%0d/%h/%0b want all 0",
                     gnt_valid_t, gnt_idx_t, gnt_onehot_t, timeout_t,
                     gnt_valid_z, gnt_idx_z, gnt_onehot_z, timeout_z);
        end
        req_a = 16'd0;
        req_t = 16'd0;
        req_z = 16'd0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a, timeout_a} !== 22'd0) begin
                n_bad++;
                $display("[TB] FAIL idle_quiet c=%0d got v=%0b i=%0d oh=%h want 0",
                         c, gnt_valid_a, gnt_idx_a, gnt_onehot_a);
            end
        end
    endtask

    task automatic test_fairness();
        int e;
        do_reset();
        req_a = 16'hFFFF;
        tick();
        for (int k = 0; k < 17; k++) begin
            e = k % 16;
            n_cmp++;
            if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== {1'b1, 4'(e), 16'd1 << e}) begin
                n_bad++;
                $display("[TB] FAIL fair_grant1 k=%0d got v=%0b i=%0d oh=%h want v=1 i=%0d",
                         k, gnt_valid_a, gnt_idx_a, gnt_onehot_a, e);
            end
            tick();
            n_cmp++;
            if ({gnt_valid_a, gnt_idx_a} !== {1'b1, 4'(e)}) begin
                n_bad++;
                $display("[TB] FAIL fair_grant2 k=%0d got v=%0b i=%0d want v=1 i=%0d",
                         k, gnt_valid_a, gnt_idx_a, e);
            end
            req_a[e] = 1'b0;
            tick();
            n_cmp++;
            if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== 21'd0) begin
                n_bad++;
                $display("[TB] FAIL fair_idle k=%0d got v=%0b i=%0d oh=%h want 0",
                         k, gnt_valid_a, gnt_idx_a, gnt_onehot_a);
            end
            req_a[e] = 1'b1;
            tick();
        end
        req_a = 16'd0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req_a = 16'h4000;
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a} !== {1'b1, 4'd14}) begin
            n_bad++;
            $display("[TB] FAIL wrap_14 got v=%0b i=%0d want v=1 i=14", gnt_valid_a, gnt_idx_a);
        end
        req_a = 16'h0000;
        tick();
        req_a = 16'h8001;
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== {1'b1, 4'd15, 16'h8000}) begin
            n_bad++;
            $display("[TB] FAIL wrap_15 got v=%0b i=%0d oh=%h want v=1 i=15 oh=8000",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a);
        end
        req_a = 16'h0001;
        tick();
        n_cmp++;
        if (gnt_valid_a !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL wrap_turnaround got v=%0b want 0", gnt_valid_a);
        end
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== {1'b1, 4'd0, 16'h0001}) begin
            n_bad++;
            $display("[TB] FAIL wrap_0 got v=%0b i=%0d oh=%h want v=1 i=0 oh=0001",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a);
        end
        req_a = 16'd0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_a = 16'h0008;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== {1'b1, 4'd3, 16'h0008}) begin
                n_bad++;
                $display("[TB] FAIL single_hold c=%0d got v=%0b i=%0d oh=%h want v=1 i=3 oh=0008",
                         c, gnt_valid_a, gnt_idx_a, gnt_onehot_a);
            end
        end
        req_a = 16'h0000;
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== 21'd0) begin
            n_bad++;
            $display("[TB] FAIL single_release got v=%0b i=%0d oh=%h want 0",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a);
        end
        req_a = 16'h0018;
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a} !== {1'b1, 4'd4}) begin
            n_bad++;
            $display("[TB] FAIL single_ptr4 got v=%0b i=%0d want v=1 i=4", gnt_valid_a, gnt_idx_a);
        end
        req_a = 16'd0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req_t = 16'h0020;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if ({gnt_valid_t, gnt_idx_t, timeout_t} !== {1'b1, 4'd5, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL to_hold c=%0d got v=%0b i=%0d to=%0b want v=1 i=5 to=0",
                         c, gnt_valid_t, gnt_idx_t, timeout_t);
            end
        end
        tick();
        n_cmp++;
        if ({gnt_valid_t, gnt_onehot_t, timeout_t} !== {1'b0, 16'd0, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL to_pulse got v=%0b oh=%h to=%0b want v=0 oh=0 to=1",
                     gnt_valid_t, gnt_onehot_t, timeout_t);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if ({gnt_valid_t, gnt_idx_t, timeout_t} !== {1'b1, 4'd5, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL to_regrant c=%0d got v=%0b i=%0d to=%0b want v=1 i=5 to=0",
                         c, gnt_valid_t, gnt_idx_t, timeout_t);
            end
            if (c == 4) req_t = 16'h0000;
        end
        tick();
        n_cmp++;
        if ({gnt_valid_t, timeout_t} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL to_simul got v=%0b to=%0b want v=0 to=0", gnt_valid_t, timeout_t);
        end
        tick();
        n_cmp++;
        if ({gnt_valid_t, timeout_t} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL to_after got v=%0b to=%0b want v=0 to=0", gnt_valid_t, timeout_t);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_a = 16'h0200;
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== {1'b1, 4'd9, 16'h0200}) begin
            n_bad++;
            $display("[TB] FAIL mid_grant9 got v=%0b i=%0d oh=%h want v=1 i=9 oh=0200",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== 21'd0) begin
            n_bad++;
            $display("[TB] FAIL mid_async_drop got v=%0b i=%0d oh=%h want 0",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a);
        end
        req_a = 16'h0201;
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({gnt_valid_a, gnt_idx_a, gnt_onehot_a} !== {1'b1, 4'd0, 16'h0001}) begin
            n_bad++;
            $display("[TB] FAIL mid_ptr0 got v=%0b i=%0d oh=%h want v=1 i=0 oh=0001",
                     gnt_valid_a, gnt_idx_a, gnt_onehot_a);
        end
        req_a = 16'd0;
        tick();
    endtask

    task automatic test_no_timeout();
        int bad_cycles;
        bad_cycles = 0;
        do_reset();
        req_z = 16'h0001;
        tick();
        for (int c = 0; c < 300; c++) begin
            if ({gnt_valid_z, gnt_idx_z, gnt_onehot_z, timeout_z} !== {1'b1, 4'd0, 16'h0001, 1'b0})
                bad_cycles++;
            tick();
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("[TB] FAIL nohold_300 got %0d bad cycles want 0", bad_cycles);
        end
        req_z = 16'd0;
        tick();
        n_cmp++;
        if ({gnt_valid_z, timeout_z} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL nohold_release got v=%0b to=%0b want 0 0", gnt_valid_z, timeout_z);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fairness();
        test_wrap();
        test_single();
        test_timeout();
        test_reset_mid_grant();
        test_no_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
